// File: rtl/custom_types.sv
// Shared core types: the 8-bit instruction word and the fetch FSM state encoding.
package custom_types;

    localparam int INSTR_W = 8;

    typedef struct packed {
        logic [3:0] opcode;
        logic [3:0] operand;
    } instruction_t;

    typedef enum logic [1:0] {
        F_IDLE  = 2'd0,
        F_REQ   = 2'd1,
        F_DRAIN = 2'd2,
        F_VALID = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, fetches one word at a time over req/ack and
// hands it to decode over valid/ready, honouring redirects from execute.
module instruction_fetch_unit
    import custom_types::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ack,
    output logic               instr_valid,
    input  logic               instr_ready,
    output instruction_t       instr,
    output logic [PC_W-1:0]    instr_pc,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_target
);

    // Handshakes: a memory transaction completes on the cycle imem_ack is high
    // while imem_req is high; an instruction transfers on instr_valid && instr_ready.
    // Neither side may change its offered payload until the transfer happens.
    fetch_state_t    state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pend_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= F_IDLE;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            pc          <= RESET_PC;
            pend_pc     <= '0;
        end else begin
            case (state)
                F_IDLE: begin
                    imem_req  <= 1'b1;
                    imem_addr <= redirect_valid ? redirect_target : pc;
                    state     <= F_REQ;
                end

                F_REQ: begin
                    if (imem_ack && !redirect_valid) begin
                        instr       <= instruction_t'(imem_rdata);
                        instr_pc    <= imem_addr;
                        pc          <= imem_addr + 1'b1;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= F_VALID;
                    end else if (imem_ack) begin
                        // Returned word belongs to the old path: start the target fetch at once.
                        imem_addr <= redirect_target;
                    end else if (redirect_valid) begin
                        // The bus cannot abort, so let the stale fetch finish before retargeting.
                        pend_pc <= redirect_target;
                        state   <= F_DRAIN;
                    end
                end

                F_DRAIN: begin
                    if (imem_ack) begin
                        imem_addr <= redirect_valid ? redirect_target : pend_pc;
                        state     <= F_REQ;
                    end else if (redirect_valid) begin
                        pend_pc <= redirect_target;
                    end
                end

                F_VALID: begin
                    if (redirect_valid) begin
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        imem_addr   <= redirect_target;
                        state       <= F_REQ;
                    end else if (instr_ready) begin
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        imem_addr   <= pc;
                        state       <= F_REQ;
                    end
                end

                default: state <= F_IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_addr_stable: assert property (@(posedge clk) disable iff (rst)
        imem_req && !imem_ack |=> imem_req && $stable(imem_addr));

    a_instr_stable: assert property (@(posedge clk) disable iff (rst)
        instr_valid && !instr_ready && !redirect_valid |=>
            instr_valid && $stable(instr) && $stable(instr_pc));

    a_ack_needs_req: assert property (@(posedge clk) disable iff (rst)
        !(imem_ack && !imem_req));
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a transaction-level fetch model.
module tb_instruction_fetch_unit;
    import custom_types::*;

    localparam int              PC_W     = 8;
    localparam logic [PC_W-1:0] RESET_PC = '0;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic [7:0]      imem_rdata;
    logic            imem_ack;
    logic            instr_valid;
    logic            instr_ready;
    instruction_t    instr;
    logic [PC_W-1:0] instr_pc;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_target;

    instruction_fetch_unit #(.PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .imem_ack        (imem_ack),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- shared state ----------------
    logic [7:0]  mem [256];
    int          tests = 0;
    int          fails = 0;
    int          cycle = 0;
    int          wait_states = 0;
    logic [15:0] exp_q[$];      // {pc, instr} the model says is being presented
    logic [15:0] got_q[$];      // {pc, instr} transferred over valid&&ready
    int          got_cyc_q[$];
    logic [7:0]  req_log[$];    // address of every new fetch request

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cycle);
        end
    endtask

    // ---------------- memory responder ----------------
    initial begin
        int   cnt;
        logic was_ack;
        cnt = 0;
        imem_ack = 1'b0;
        imem_rdata = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            was_ack    = imem_ack;
            imem_ack   = 1'b0;
            imem_rdata = 8'($urandom);
            if (rst || !imem_req) begin
                cnt = 0;
            end else begin
                cnt = was_ack ? 1 : cnt + 1;
                if (cnt >= wait_states + 2) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem[imem_addr];
                end
            end
        end
    end

    // ---------------- model + compare (negedge) ----------------
    logic            s_rst = 1'b1, s_ready, s_redir, s_ack;
    logic [PC_W-1:0] s_tgt;
    logic            p_req, p_valid;
    logic [PC_W-1:0] p_addr, p_pc;
    logic [7:0]      p_instr;
    logic            from_reset, pending, stale, new_issue, good_ack, exp_req_now;
    logic [PC_W-1:0] pend_tgt, next_seq, exp_addr;

    always @(negedge clk) begin
        cycle++;
        if (rst || s_rst) begin
            check("rst_imem_req", imem_req, 1'b0);
            check("rst_imem_addr", imem_addr, RESET_PC);
            check("rst_instr_valid", instr_valid, 1'b0);
            check("rst_instr", instr, 8'h00);
            check("rst_instr_pc", instr_pc, 8'h00);
            from_reset = 1'b1;
            pending    = 1'b0;
            stale      = 1'b0;
            next_seq   = RESET_PC;
            exp_q.delete();
        end else begin
            new_issue = 1'b0;
            good_ack  = 1'b0;
            if (s_redir) begin
                pending  = 1'b1;
                pend_tgt = s_tgt;
                if (p_req) stale = 1'b1;
            end
            if (p_valid && (s_ready || s_redir)) begin
                if (s_ready) begin
                    got_q.push_back({p_pc, p_instr});
                    got_cyc_q.push_back(cycle);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                new_issue = 1'b1;
            end else if (from_reset) begin
                new_issue = 1'b1;
            end else if (p_req && s_ack) begin
                if (stale) begin
                    new_issue = 1'b1;
                end else begin
                    good_ack = 1'b1;
                    exp_q.push_back({p_addr, mem[p_addr]});
                    next_seq = p_addr + 8'd1;
                end
            end
            from_reset  = 1'b0;
            exp_req_now = new_issue ? 1'b1 : (good_ack ? 1'b0 : p_req);

            check("imem_req", imem_req, exp_req_now);
            if (new_issue) begin
                exp_addr = pending ? pend_tgt : next_seq;
                pending  = 1'b0;
                stale    = 1'b0;
                check("req_addr", imem_addr, exp_addr);
                req_log.push_back(imem_addr);
            end else if (exp_req_now) begin
                check("addr_stable", imem_addr, p_addr);
            end
            check("instr_valid", instr_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                check("instr", instr, exp_q[0][7:0]);
                check("instr_pc", instr_pc, exp_q[0][15:8]);
            end
        end
        p_req   = imem_req;
        p_valid = instr_valid;
        p_addr  = imem_addr;
        p_pc    = instr_pc;
        p_instr = instr;
        s_rst   = rst;
        s_ready = instr_ready;
        s_redir = redirect_valid;
        s_ack   = imem_ack;
        s_tgt   = redirect_target;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_pulse(input logic [PC_W-1:0] tgt);
        redirect_valid  = 1'b1;
        redirect_target = tgt;
        tick();
        redirect_valid  = 1'b0;
    endtask

    task automatic wait_got(input int n, input string name);
        for (int i = 0; i < 200 && got_q.size() < n; i++) tick();
        check({name, "_timeout"}, got_q.size() >= n, 1'b1);
    endtask

    task automatic wait_req(input int n, input string name);
        for (int i = 0; i < 200 && req_log.size() < n; i++) tick();
        check({name, "_timeout"}, req_log.size() >= n, 1'b1);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int g;
        int rl;
        int n;
        int i;
        instr_ready     = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        for (int k = 0; k < 256; k++) mem[k] = 8'(k * 37 + 11);
        mem[0] = 8'h5B;
        mem[1] = 8'hB6;
        mem[2] = 8'hC1;
        mem[4] = 8'hF3;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;

        // In-order fetch after reset, zero-wait memory
        wait_got(5, "t1_fetch");
        check("t1_got0", got_q[0], 16'h005B);
        check("t1_got1", got_q[1], 16'h01B6);
        check("t1_got2", got_q[2], 16'h02C1);
        check("t1_illegal_op", got_q[4], 16'h04F3);
        check("t1_period", got_cyc_q[2] - got_cyc_q[1], 3);

        // Wait states stretch the period by one cycle each
        wait_states = 3;
        n = got_q.size();
        wait_got(n + 3, "t2_fetch");
        check("t2_period", got_cyc_q[n + 2] - got_cyc_q[n + 1], 6);

        // Back-pressure holds the instruction and stalls fetch
        wait_states = 0;
        instr_ready = 1'b0;
        redirect_pulse(8'h20);
        for (i = 0; i < 60 && !(instr_valid && instr_pc == 8'h20); i++) tick();
        check("t3_valid_timeout", instr_valid && instr_pc == 8'h20, 1'b1);
        repeat (5) begin
            tick();
            check("t3_hold_instr", instr, 8'hAB);
            check("t3_hold_pc", instr_pc, 8'h20);
            check("t3_hold_valid", instr_valid, 1'b1);
            check("t3_no_req", imem_req, 1'b0);
        end
        rl = req_log.size();
        instr_ready = 1'b1;
        wait_req(rl + 1, "t3_next_req");
        check("t3_next_addr", req_log[rl], 8'h21);

        // Redirects during an outstanding fetch: latest target wins
        wait_states = 6;
        redirect_pulse(8'h03);
        for (i = 0; i < 60 && !(imem_req && imem_addr == 8'h03); i++) tick();
        check("t4_addr3_timeout", imem_req && imem_addr == 8'h03, 1'b1);
        tick();
        redirect_pulse(8'h40);
        tick();
        tick();
        redirect_pulse(8'h50);
        rl = req_log.size();
        g  = got_q.size();
        wait_req(rl + 1, "t4_drain_req");
        check("t4_drain_addr", req_log[rl], 8'h50);
        wait_got(g + 1, "t4_drain_got");
        check("t4_drain_instr", got_q[g], 16'h509B);
        for (i = 0; i < 60 && !(imem_req && imem_addr == 8'h51); i++) tick();
        tick();
        redirect_pulse(8'h40);
        rl = req_log.size();
        g  = got_q.size();
        wait_req(rl + 1, "t4_single_req");
        check("t4_single_addr", req_log[rl], 8'h40);
        wait_got(g + 1, "t4_single_got");
        check("t4_single_instr", got_q[g], 16'h404B);

        // Redirect in the valid state with ready: handshake counts, fetch from target
        wait_states = 0;
        for (i = 0; i < 60 && !instr_valid; i++) tick();
        g  = got_q.size();
        rl = req_log.size();
        redirect_pulse(8'h80);
        wait_req(rl + 1, "t5_valid_req");
        check("t5_valid_addr", req_log[rl], 8'h80);
        check("t5_consumed", got_q.size(), g + 1);
        wait_got(g + 2, "t5_valid_got");
        check("t5_valid_instr", got_q[g + 1], 16'h808B);

        // Redirect coinciding with ack: returned word is dropped
        wait_states = 2;
        for (i = 0; i < 60 && !imem_ack; i++) begin
            @(posedge clk);
            #2;
        end
        check("t5_ack_timeout", imem_ack, 1'b1);
        redirect_valid  = 1'b1;
        redirect_target = 8'hA0;
        g  = got_q.size();
        rl = req_log.size();
        tick();
        redirect_valid = 1'b0;
        wait_req(rl + 1, "t5_ack_req");
        check("t5_ack_addr", req_log[rl], 8'hA0);
        wait_got(g + 1, "t5_ack_got");
        check("t5_ack_instr", got_q[g], 16'hA02B);

        // PC wraps from 8'hFF to 8'h00
        wait_states = 0;
        redirect_pulse(8'hFE);
        tick();
        g = got_q.size();
        wait_got(g + 3, "t6_wrap");
        check("t6_wrap_fe", got_q[g], 16'hFEC1);
        check("t6_wrap_ff", got_q[g + 1], 16'hFFE6);
        check("t6_wrap_00", got_q[g + 2], 16'h005B);

        // Reset in the middle of a wait-stated fetch
        wait_states = 5;
        for (i = 0; i < 60 && !(imem_req && !imem_ack); i++) tick();
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        check("t6_async_req", imem_req, 1'b0);
        check("t6_async_valid", instr_valid, 1'b0);
        check("t6_async_addr", imem_addr, RESET_PC);
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        wait_states = 0;
        rl = req_log.size();
        g  = got_q.size();
        wait_req(rl + 1, "t6_refetch_req");
        check("t6_refetch_addr", req_log[rl], RESET_PC);
        wait_got(g + 1, "t6_refetch_got");
        check("t6_refetch_instr", got_q[g], 16'h005B);

        repeat (5) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog: actual timeout required completion (cycle %0d)", cycle);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
